// File: rtl/sdrd_read_sequencer.sv
// Serial-read sequencer for the card's serial device port.
// A qualified bus read starts a command that shifts WIDTH bits in MSB first from one of
// CHANNELS serial inputs. The command then presents the word on q and drives sdrd with
// either the word MSB or its parity until the bus deselects.
module sdrd_read_sequencer #(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned CHANNELS = 2,
    parameter logic [1:0]  PAGE     = 2'b01
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sser_n,
    input  logic [1:0]          ba_hi,
    input  logic [3:0]          ba_cmd,
    input  logic                br_w,
    input  logic                oe,
    input  logic [CHANNELS-1:0] sdi,
    output logic [WIDTH-1:0]    q,
    output logic                q_en,
    output logic                sdrd,
    output logic                sdrd_en,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic [1:0] OpRead    = 2'b01;
    localparam logic [1:0] OpReadPar = 2'b10;
    localparam logic [1:0] OpAbort   = 2'b11;

    state_e            state_q;
    // The MSB of the incoming word is never read back before it lands in q, so only
    // WIDTH-1 bits of history are kept.
    logic [WIDTH-2:0]  shreg_q;
    logic [CntW-1:0]   count_q;
    logic              parity_q;
    logic              mode_q;   // 1 = READ_PAR
    logic [1:0]        ch_q;
    logic [WIDTH-1:0]  q_q;

    logic              sel;
    logic [1:0]        op;
    logic              ch_valid;
    logic              start;
    logic              sdi_bit;
    logic [WIDTH-1:0]  shifted;

    assign sel      = ~sser_n & (ba_hi == PAGE) & br_w;
    assign op       = ba_cmd[3:2];
    assign ch_valid = {30'd0, ba_cmd[1:0]} < CHANNELS;
    assign start    = ch_valid & ((op == OpRead) | (op == OpReadPar));
    assign shifted  = {shreg_q, sdi_bit};

    // Select the serial input of the latched channel.
    always_comb begin
        sdi_bit = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (ch_q == 2'(i)) sdi_bit = sdi[i];
        end
    end

    // Sequencer FSM: deselect beats abort, abort beats the final shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            count_q  <= '0;
            parity_q <= 1'b0;
            mode_q   <= 1'b0;
            ch_q     <= 2'b00;
            q_q      <= '0;
        end else if (!sel) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            count_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        ch_q     <= ba_cmd[1:0];
                        mode_q   <= (op == OpReadPar);
                        count_q  <= CntW'(WIDTH - 1);
                        shreg_q  <= '0;
                        parity_q <= 1'b0;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    if (op == OpAbort) begin
                        shreg_q  <= '0;
                        count_q  <= '0;
                        parity_q <= 1'b0;
                        state_q  <= StIdle;
                    end else begin
                        shreg_q  <= shifted[WIDTH-2:0];
                        parity_q <= parity_q ^ sdi_bit;
                        if (count_q == '0) begin
                            q_q     <= shifted;
                            state_q <= StDone;
                        end else begin
                            count_q <= count_q - 1'b1;
                        end
                    end
                end
                StDone: begin
                    // Held until deselect; commands are ignored here.
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output decode from the state register plus the live select.
    always_comb begin
        busy    = (state_q == StShift);
        done    = (state_q == StDone);
        sdrd_en = sel & done;
        sdrd    = sdrd_en & (mode_q ? parity_q : q_q[WIDTH-1]);
        q       = q_q;
        q_en    = oe;
    end

endmodule
